// File: rtl/dma_writer.sv
// dma_writer: copies i_count words from a packed word buffer into word-addressed
// memory starting at i_address, one registered write per clock.
`default_nettype none

module dma_writer #(
  parameter int BUFFER_SIZE       = 120,
  parameter int WORD_SIZE         = 16,
  parameter int MEM_ADDRESS_WIDTH = 3
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                i_write,
  input  logic [MEM_ADDRESS_WIDTH-1:0]        i_address,
  input  logic [MEM_ADDRESS_WIDTH-1:0]        i_count,
  input  logic [BUFFER_SIZE*WORD_SIZE-1:0]    i_buffer,
  output logic [MEM_ADDRESS_WIDTH-1:0]        o_mem_addr,
  output logic [WORD_SIZE-1:0]                o_mem_data,
  output logic                                o_mem_write,
  output logic                                o_busy,
  output logic                                o_done
);

  localparam int MAX_COUNT = 2**MEM_ADDRESS_WIDTH - 1;
  localparam int CLAMP     = (BUFFER_SIZE < MAX_COUNT) ? BUFFER_SIZE : MAX_COUNT;
  localparam logic [MEM_ADDRESS_WIDTH-1:0] COUNT_LIMIT = MEM_ADDRESS_WIDTH'(CLAMP);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e                         state_q, state_d;
  logic [MEM_ADDRESS_WIDTH-1:0]   idx_q, idx_d;
  logic [MEM_ADDRESS_WIDTH-1:0]   base_q, base_d;
  logic [MEM_ADDRESS_WIDTH-1:0]   n_q, n_d;
  logic [MEM_ADDRESS_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [WORD_SIZE-1:0]           mem_data_q, mem_data_d;
  logic                           mem_write_q, mem_write_d;
  logic                           busy_q, busy_d;
  logic                           done_q, done_d;

  // Outputs are registered, so word 0 is staged on the start edge and idx_q
  // then holds the number of words already presented (the next index to send).
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    base_d      = base_q;
    n_d         = n_q;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    mem_write_d = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_write) begin
          if (i_count == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            base_d      = i_address;
            n_d         = (i_count > COUNT_LIMIT) ? COUNT_LIMIT : i_count;
            mem_addr_d  = i_address;
            mem_data_d  = i_buffer[WORD_SIZE-1:0];
            mem_write_d = 1'b1;
            busy_d      = 1'b1;
            idx_d       = MEM_ADDRESS_WIDTH'(1);
            state_d     = S_WRITE;
          end
        end
      end

      S_WRITE: begin
        if (idx_q == n_q) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          mem_addr_d  = base_q + idx_q;
          mem_data_d  = i_buffer[int'(idx_q)*WORD_SIZE +: WORD_SIZE];
          mem_write_d = 1'b1;
          busy_d      = 1'b1;
          idx_d       = idx_q + 1'b1;
        end
      end

      S_DONE: begin
        if (i_write) begin
          done_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      base_q      <= '0;
      n_q         <= '0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      mem_write_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      base_q      <= base_d;
      n_q         <= n_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      mem_write_q <= mem_write_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign o_mem_addr  = mem_addr_q;
  assign o_mem_data  = mem_data_q;
  assign o_mem_write = mem_write_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_dma_writer.sv
// tb_dma_writer: directed self-checking bench for dma_writer with a small
// memory model capturing writes.
`default_nettype none

module tb_dma_writer;

  localparam int BUFFER_SIZE       = 120;
  localparam int WORD_SIZE         = 16;
  localparam int MEM_ADDRESS_WIDTH = 3;

  logic                             clk = 1'b0;
  logic                             rst_n;
  logic                             i_write;
  logic [MEM_ADDRESS_WIDTH-1:0]     i_address;
  logic [MEM_ADDRESS_WIDTH-1:0]     i_count;
  logic [BUFFER_SIZE*WORD_SIZE-1:0] i_buffer;
  logic [MEM_ADDRESS_WIDTH-1:0]     o_mem_addr;
  logic [WORD_SIZE-1:0]             o_mem_data;
  logic                             o_mem_write;
  logic                             o_busy;
  logic                             o_done;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [WORD_SIZE-1:0] mem [8];
  logic                 mem_inited = 1'b0;
  int                   wr_count   = 0;

  dma_writer #(
    .BUFFER_SIZE      (BUFFER_SIZE),
    .WORD_SIZE        (WORD_SIZE),
    .MEM_ADDRESS_WIDTH(MEM_ADDRESS_WIDTH)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_write    (i_write),
    .i_address  (i_address),
    .i_count    (i_count),
    .i_buffer   (i_buffer),
    .o_mem_addr (o_mem_addr),
    .o_mem_data (o_mem_data),
    .o_mem_write(o_mem_write),
    .o_busy     (o_busy),
    .o_done     (o_done)
  );

  always #5 clk = ~clk;

  // Memory model: preloaded with 16'hF000+addr, then captures qualified writes.
  always @(posedge clk) begin
    if (!mem_inited) begin
      for (int i = 0; i < 8; i++) mem[i] <= 16'hF000 + 16'(i);
      mem_inited <= 1'b1;
    end else if (o_mem_write) begin
      mem[o_mem_addr] <= o_mem_data;
      wr_count        <= wr_count + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_word(input int i, input logic [WORD_SIZE-1:0] v);
    i_buffer[i*WORD_SIZE +: WORD_SIZE] = v;
  endtask

  task automatic wait_done(input int budget, output int edges);
    edges = 0;
    do begin
      @(negedge clk);
      edges++;
    end while (!o_done && edges < budget);
  endtask

  int edges;
  int w0;

  initial begin
    rst_n     = 1'b0;
    i_write   = 1'b0;
    i_address = '0;
    i_count   = '0;
    i_buffer  = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_write", o_mem_write, 0);
    check("rst_addr",  o_mem_addr,  0);
    check("rst_data",  o_mem_data,  0);
    check("rst_busy",  o_busy,      0);
    check("rst_done",  o_done,      0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic transfer: addr 1, 4 words
    set_word(0, 16'hA0); set_word(1, 16'hA1); set_word(2, 16'hA2); set_word(3, 16'hA3);
    i_address = 3'd1; i_count = 3'd4; i_write = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("basic_we",   o_mem_write, 1);
      check("basic_busy", o_busy,      1);
      check("basic_addr", o_mem_addr,  32'(1 + k));
      check("basic_data", o_mem_data,  32'(16'hA0 + k));
      check("basic_nodone", o_done,    0);
    end
    @(negedge clk);
    check("basic_done", o_done,      1);
    check("basic_we0",  o_mem_write, 0);
    check("basic_busy0", o_busy,     0);
    check("basic_m0", mem[0], 16'hF000);
    check("basic_m1", mem[1], 16'hA0);
    check("basic_m2", mem[2], 16'hA1);
    check("basic_m3", mem[3], 16'hA2);
    check("basic_m4", mem[4], 16'hA3);
    check("basic_m5", mem[5], 16'hF005);
    check("basic_m6", mem[6], 16'hF006);
    check("basic_m7", mem[7], 16'hF007);
    i_write = 1'b0;
    @(negedge clk);
    check("basic_done_clr", o_done, 0);

    // Wrap-around: addr 6, 3 words -> 6, 7, 0
    set_word(0, 16'h11); set_word(1, 16'h22); set_word(2, 16'h33);
    i_address = 3'd6; i_count = 3'd3; i_write = 1'b1;
    w0 = wr_count;
    wait_done(20, edges);
    check("wrap_done",   o_done, 1);
    check("wrap_edges",  edges, 4);
    check("wrap_nwr",    wr_count - w0, 3);
    check("wrap_m6", mem[6], 16'h11);
    check("wrap_m7", mem[7], 16'h22);
    check("wrap_m0", mem[0], 16'h33);
    check("wrap_m1", mem[1], 16'hA0);
    check("wrap_m5", mem[5], 16'hF005);
    i_write = 1'b0;
    @(negedge clk);

    // Zero count, then held request
    i_address = 3'd2; i_count = 3'd0; i_write = 1'b1;
    w0 = wr_count;
    @(negedge clk);
    check("zero_done", o_done,      1);
    check("zero_we",   o_mem_write, 0);
    check("zero_busy", o_busy,      0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("held_done", o_done,      1);
      check("held_we",   o_mem_write, 0);
    end
    check("held_nwr", wr_count - w0, 0);
    i_write = 1'b0;
    @(negedge clk);
    check("held_clr", o_done, 0);

    // Retrigger: addr 0, 2 words
    set_word(0, 16'hB0); set_word(1, 16'hB1);
    i_address = 3'd0; i_count = 3'd2; i_write = 1'b1;
    w0 = wr_count;
    wait_done(20, edges);
    check("retrig_done",  o_done, 1);
    check("retrig_edges", edges, 3);
    check("retrig_nwr",   wr_count - w0, 2);
    check("retrig_m0", mem[0], 16'hB0);
    check("retrig_m1", mem[1], 16'hB1);
    check("retrig_m2", mem[2], 16'hA1);
    i_write = 1'b0;
    @(negedge clk);

    // Reset mid-transfer after the third write
    for (int k = 0; k < 7; k++) set_word(k, 16'hC0 + 16'(k));
    i_address = 3'd0; i_count = 3'd7; i_write = 1'b1;
    w0 = wr_count;
    repeat (4) @(negedge clk);
    check("mid_addr3", o_mem_addr, 3);
    #1 rst_n = 1'b0;
    #1;
    check("mid_we",   o_mem_write, 0);
    check("mid_addr", o_mem_addr,  0);
    check("mid_data", o_mem_data,  0);
    check("mid_busy", o_busy,      0);
    check("mid_done", o_done,      0);
    check("mid_nwr",  wr_count - w0, 3);
    check("mid_m0", mem[0], 16'hC0);
    check("mid_m1", mem[1], 16'hC1);
    check("mid_m2", mem[2], 16'hC2);
    check("mid_m3", mem[3], 16'hA2);
    check("mid_m4", mem[4], 16'hA3);
    check("mid_m5", mem[5], 16'hF005);
    check("mid_m6", mem[6], 16'h11);
    i_write = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_idle_busy", o_busy,      0);
    check("mid_idle_done", o_done,      0);
    check("mid_idle_we",   o_mem_write, 0);

    // Input changes after the start edge are ignored
    set_word(0, 16'hD0); set_word(1, 16'hD1); set_word(2, 16'hD2); set_word(3, 16'hD3);
    i_address = 3'd1; i_count = 3'd4; i_write = 1'b1;
    w0 = wr_count;
    @(negedge clk);
    i_address = 3'd5; i_count = 3'd1;
    wait_done(20, edges);
    check("chg_done",  o_done, 1);
    check("chg_edges", edges + 1, 5);
    check("chg_nwr",   wr_count - w0, 4);
    check("chg_m1", mem[1], 16'hD0);
    check("chg_m2", mem[2], 16'hD1);
    check("chg_m3", mem[3], 16'hD2);
    check("chg_m4", mem[4], 16'hD3);
    check("chg_m5", mem[5], 16'hF005);
    i_write = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
